// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Raster timing generator. Produces the pixel column/line counters used by
// the renderers, the sync and active-video decodes aligned with those
// counters, one-clk line/frame start pulses, and copies of sync/active
// delayed by PIPE_DELAY clk cycles to line up with registered RGB.
//
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous, active-high reset
//   h_counter   out  pixel column, 0..H_TOTAL-1
//   v_counter   out  line, 0..V_TOTAL-1
//   pixel_tick  out  last clk cycle of each pixel period
//   hsync       out  horizontal sync (asserted level = SYNC_ACTIVE)
//   vsync       out  vertical sync (asserted level = SYNC_ACTIVE)
//   active      out  counters are inside the visible area
//   line_start  out  one-clk pulse on the first cycle after a line wrap
//   frame_start out  one-clk pulse on the first cycle after a frame wrap
//   hsync_d     out  hsync delayed PIPE_DELAY clk cycles
//   vsync_d     out  vsync delayed PIPE_DELAY clk cycles
//   active_d    out  active delayed PIPE_DELAY clk cycles
module vga_timing_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int CLK_DIV     = 2,
    parameter bit SYNC_ACTIVE = 1'b0,
    parameter int PIPE_DELAY  = 1
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] h_counter,
    output logic [9:0] v_counter,
    output logic       pixel_tick,
    output logic       hsync,
    output logic       vsync,
    output logic       active,
    output logic       line_start,
    output logic       frame_start,
    output logic       hsync_d,
    output logic       vsync_d,
    output logic       active_d
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] r_div_cnt;
    logic [9:0]       r_h, r_v;
    logic             r_hsync, r_vsync, r_active;
    logic             r_line_start, r_frame_start;

    logic       w_tick;
    logic       w_h_wrap;
    logic [9:0] w_h_nxt, w_v_nxt;

    // With CLK_DIV=1 the divider sits at 0 and the tick is permanently high.
    assign w_tick   = (r_div_cnt == DIV_LAST);
    assign w_h_wrap = w_tick && (r_h == H_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_div_cnt <= '0;
        else if (w_tick)
            r_div_cnt <= '0;
        else
            r_div_cnt <= r_div_cnt + DIV_W'(1);
    end

    always_comb begin
        w_h_nxt = r_h;
        w_v_nxt = r_v;
        if (w_tick) begin
            if (r_h == H_LAST) begin
                w_h_nxt = '0;
                w_v_nxt = (r_v == V_LAST) ? '0 : r_v + 10'd1;
            end else begin
                w_h_nxt = r_h + 10'd1;
            end
        end
    end

    // Decodes are taken from the next counter values so they change on the
    // same edge as the counters (zero counter-to-sync latency).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_h           <= '0;
            r_v           <= '0;
            r_hsync       <= ~SYNC_ACTIVE;
            r_vsync       <= ~SYNC_ACTIVE;
            r_active      <= 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_h           <= w_h_nxt;
            r_v           <= w_v_nxt;
            r_hsync       <= (w_h_nxt >= HS_BEG && w_h_nxt <= HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_vsync       <= (w_v_nxt >= VS_BEG && w_v_nxt <= VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_active      <= (w_h_nxt < H_VIS) && (w_v_nxt < V_VIS);
            r_line_start  <= w_h_wrap;
            r_frame_start <= w_h_wrap && (r_v == V_LAST);
        end
    end

    assign h_counter   = r_h;
    assign v_counter   = r_v;
    assign pixel_tick  = w_tick;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign active      = r_active;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

    // Delay line runs every clk, independent of the pixel tick.
    generate
        if (PIPE_DELAY == 0) begin : g_nodly
            assign hsync_d  = r_hsync;
            assign vsync_d  = r_vsync;
            assign active_d = r_active;
        end else begin : g_dly
            logic [PIPE_DELAY-1:0][2:0] r_dly;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < PIPE_DELAY; i++)
                        r_dly[i] <= {~SYNC_ACTIVE, ~SYNC_ACTIVE, 1'b0};
                end else begin
                    r_dly[0] <= {r_hsync, r_vsync, r_active};
                    for (int i = 1; i < PIPE_DELAY; i++)
                        r_dly[i] <= r_dly[i-1];
                end
            end

            assign hsync_d  = r_dly[PIPE_DELAY-1][2];
            assign vsync_d  = r_dly[PIPE_DELAY-1][1];
            assign active_d = r_dly[PIPE_DELAY-1][0];
        end
    endgenerate

endmodule
